// File: rtl/rbb_pkg.sv
// Shared types and sizing for the result batch buffer: state encoding,
// bus widths and helpers that split a PE word address into line and word.
package rbb_pkg;

    localparam int unsigned RBB_LINE_ADDR_WIDTH = 4;
    localparam int unsigned RBB_WORD_DATA_WIDTH = 32;
    localparam int unsigned WORDS_PER_LINE      = 16;
    localparam int unsigned WORD_SEL_WIDTH      = 4;
    localparam int unsigned RBB_LINE_DATA_WIDTH = WORDS_PER_LINE * RBB_WORD_DATA_WIDTH;
    localparam int unsigned RBB_WORD_ADDR_WIDTH = RBB_LINE_ADDR_WIDTH + WORD_SEL_WIDTH;
    localparam int unsigned NUM_LINES           = 1 << RBB_LINE_ADDR_WIDTH;

    typedef enum logic [3:0] {
        RBB_RESET = 4'b0001,
        RBB_FILL  = 4'b0010,
        RBB_FETCH = 4'b0100,
        RBB_SEND  = 4'b1000
    } rbb_state_e;

    typedef logic [RBB_LINE_ADDR_WIDTH-1:0] line_idx_t;
    typedef logic [WORD_SEL_WIDTH-1:0]      word_sel_t;
    typedef logic [RBB_WORD_ADDR_WIDTH-1:0] word_addr_t;
    typedef logic [RBB_WORD_DATA_WIDTH-1:0] word_data_t;
    typedef logic [RBB_LINE_DATA_WIDTH-1:0] line_data_t;

    // Low bits of a PE word address pick the bank (word within line).
    function automatic word_sel_t word_sel(input word_addr_t addr);
        return addr[WORD_SEL_WIDTH-1:0];
    endfunction

    // High bits of a PE word address pick the line.
    function automatic line_idx_t line_sel(input word_addr_t addr);
        return addr[RBB_WORD_ADDR_WIDTH-1:WORD_SEL_WIDTH];
    endfunction

    function automatic line_idx_t last_line();
        return RBB_LINE_ADDR_WIDTH'(NUM_LINES - 1);
    endfunction

endpackage

// File: rtl/nlb_gram_sdp.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// Contents are never reset; read-during-write to the same address is unspecified.
module nlb_gram_sdp #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
        dout <= mem[raddr];
    end

endmodule

// File: rtl/rbb_word_bank.sv
// Sixteen word-wide RAM banks side by side; a word write hits one bank,
// a line read returns all banks concatenated with word k at bits [32k+31:32k].
module rbb_word_bank
    import rbb_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  word_addr_t wr_addr,
    input  word_data_t wr_din,
    input  line_idx_t  rd_line,
    output line_data_t rd_data
);

    line_idx_t wr_line;
    word_sel_t wr_word;

    assign wr_line = line_sel(wr_addr);
    assign wr_word = word_sel(wr_addr);

    for (genvar k = 0; k < int'(WORDS_PER_LINE); k++) begin : g_bank
        logic       bank_we;
        word_data_t bank_dout;

        assign bank_we = wr_en && (wr_word == WORD_SEL_WIDTH'(k));

        nlb_gram_sdp #(
            .ADDR_WIDTH (RBB_LINE_ADDR_WIDTH),
            .DATA_WIDTH (RBB_WORD_DATA_WIDTH)
        ) u_ram (
            .clk   (clk),
            .we    (bank_we),
            .waddr (wr_line),
            .din   (wr_din),
            .raddr (rd_line),
            .dout  (bank_dout)
        );

        assign rd_data[k*RBB_WORD_DATA_WIDTH +: RBB_WORD_DATA_WIDTH] = bank_dout;
    end

endmodule

// File: rtl/rbb.sv
// Result batch buffer: collects PE result words for one batch, then drains
// the batch to the host one 512-bit line per request/acknowledge handshake.
module rbb
    import rbb_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           WrEn,
    input  logic [RBB_WORD_ADDR_WIDTH-1:0] WrAddr,
    input  logic [RBB_WORD_DATA_WIDTH-1:0] WrDin,
    output logic                           Ready,
    input  logic                           result_done,
    output logic                           ReqValid,
    output logic [RBB_LINE_ADDR_WIDTH-1:0] ReqLineIdx,
    output logic [RBB_LINE_DATA_WIDTH-1:0] ReqData,
    input  logic                           ReqAck,
    output logic                           batch_written
);

    rbb_state_e state;
    line_idx_t  line_counter;
    line_data_t bank_data;
    logic       in_fill;
    logic       in_send;
    logic       last_ack;

    assign in_fill  = (state == RBB_FILL);
    assign in_send  = (state == RBB_SEND);
    assign last_ack = in_send && ReqAck && (line_counter == last_line());

    // Batch sequencing; the counter only moves on a host acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RBB_RESET;
            line_counter <= '0;
        end else begin
            case (state)
                RBB_RESET: state <= RBB_FILL;
                RBB_FILL: begin
                    if (result_done) begin
                        state <= RBB_FETCH;
                    end
                end
                RBB_FETCH: state <= RBB_SEND;
                RBB_SEND: begin
                    if (ReqAck) begin
                        if (line_counter == last_line()) begin
                            line_counter <= '0;
                            state        <= RBB_FILL;
                        end else begin
                            line_counter <= line_counter + RBB_LINE_ADDR_WIDTH'(1);
                            state        <= RBB_FETCH;
                        end
                    end
                end
                default: state <= RBB_RESET;
            endcase
        end
    end

    // Read address follows the counter; FETCH gives the RAM its one read cycle.
    rbb_word_bank u_bank (
        .clk     (clk),
        .wr_en   (WrEn && in_fill),
        .wr_addr (WrAddr),
        .wr_din  (WrDin),
        .rd_line (line_counter),
        .rd_data (bank_data)
    );

    // Outputs decode straight off the state flop so reset clears them at once.
    assign Ready         = in_fill;
    assign ReqValid      = in_send;
    assign ReqLineIdx    = in_send ? line_counter : '0;
    assign ReqData       = in_send ? bank_data : '0;
    assign batch_written = last_ack;

endmodule

// File: tb/tb_rbb.sv
// Directed bench for rbb: fills batches, drains them and checks every line
// against a word-level model, including stalls, drops, same-cycle writes and reset.
module tb_rbb;

    logic         clk;
    logic         reset_n;
    logic         WrEn;
    logic [7:0]   WrAddr;
    logic [31:0]  WrDin;
    logic         Ready;
    logic         result_done;
    logic         ReqValid;
    logic [3:0]   ReqLineIdx;
    logic [511:0] ReqData;
    logic         ReqAck;
    logic         batch_written;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] model [16][16];

    rbb dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .WrEn          (WrEn),
        .WrAddr        (WrAddr),
        .WrDin         (WrDin),
        .Ready         (Ready),
        .result_done   (result_done),
        .ReqValid      (ReqValid),
        .ReqLineIdx    (ReqLineIdx),
        .ReqData       (ReqData),
        .ReqAck        (ReqAck),
        .batch_written (batch_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] exp_line(input int line);
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = model[line][k];
        return v;
    endfunction

    // Writes every word with {line, word} ^ pat; skip_addr (< 0 for none) is left untouched.
    task automatic fill(input logic [31:0] pat, input int skip_addr);
        for (int a = 0; a < 256; a++) begin
            if (a != skip_addr) begin
                @(negedge clk);
                WrEn   = 1'b1;
                WrAddr = 8'(a);
                WrDin  = {16'(a / 16), 16'(a % 16)} ^ pat;
                model[a / 16][a % 16] = WrDin;
            end
        end
        @(negedge clk);
        WrEn = 1'b0;
    endtask

    // Pulses result_done and walks the drain line by line. Starts and ends at a negedge in FILL.
    task automatic drain(input int stall_line, input int abort_line,
                         input bit drop_write, input bit write_with_done);
        result_done = 1'b1;
        if (write_with_done) begin
            WrEn = 1'b1; WrAddr = 8'hF0; WrDin = 32'h12345678;
            model[15][0] = 32'h12345678;
        end
        @(posedge clk); @(negedge clk);
        result_done = 1'b0;
        WrEn = 1'b0;
        n_cmp++;
        if (ReqValid !== 1'b0 || Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch0: ReqValid=%b Ready=%b, want 0 0", ReqValid, Ready);
        end
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (ReqValid !== 1'b1 || ReqLineIdx !== 4'(i) || Ready !== 1'b0) begin
                n_fail++;
                $display("FAIL send_ctl line %0d: ReqValid=%b ReqLineIdx=%0d Ready=%b, want 1 %0d 0",
                         i, ReqValid, ReqLineIdx, Ready, i);
            end
            n_cmp++;
            if (ReqData !== exp_line(i)) begin
                n_fail++;
                $display("FAIL send_data line %0d: got %h want %h", i, ReqData, exp_line(i));
            end
            if (i == abort_line) begin
                reset_n = 1'b0;
                #1;
                n_cmp++;
                if (ReqValid !== 1'b0 || Ready !== 1'b0 || ReqData !== '0 || batch_written !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_reset: ReqValid=%b Ready=%b batch_written=%b, want 0 0 0",
                             ReqValid, Ready, batch_written);
                end
                @(posedge clk); @(negedge clk);
                reset_n = 1'b1;
                n_cmp++;
                if (Ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_release: Ready=%b want 0", Ready);
                end
                @(posedge clk); @(negedge clk);
                n_cmp++;
                if (Ready !== 1'b1 || ReqValid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_fill: Ready=%b ReqValid=%b, want 1 0", Ready, ReqValid);
                end
                return;
            end
            if (i == stall_line) begin
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); @(negedge clk);
                    n_cmp++;
                    if (ReqValid !== 1'b1 || ReqLineIdx !== 4'(i) || ReqData !== exp_line(i)
                        || batch_written !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall line %0d cyc %0d: ReqValid=%b ReqLineIdx=%0d data_ok=%b",
                                 i, s, ReqValid, ReqLineIdx, ReqData === exp_line(i));
                    end
                end
            end
            if (drop_write && i == 2) begin
                WrEn = 1'b1; WrAddr = 8'h25; WrDin = 32'hDEADBEEF;
            end
            ReqAck = 1'b1;
            #1;
            n_cmp++;
            if (batch_written !== (i == 15)) begin
                n_fail++;
                $display("FAIL batch_written line %0d: got %b want %b", i, batch_written, i == 15);
            end
            @(posedge clk); @(negedge clk);
            ReqAck = 1'b0;
            WrEn   = 1'b0;
            n_cmp++;
            if (ReqValid !== 1'b0 || batch_written !== 1'b0 || Ready !== (i == 15)) begin
                n_fail++;
                $display("FAIL after_ack line %0d: ReqValid=%b batch_written=%b Ready=%b, want 0 0 %b",
                         i, ReqValid, batch_written, Ready, i == 15);
            end
            if (i < 15) begin
                @(posedge clk); @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; WrEn = 1'b0; WrAddr = '0; WrDin = '0;
        result_done = 1'b0; ReqAck = 1'b0;
        #3;
        n_cmp++;
        if (Ready !== 1'b0 || ReqValid !== 1'b0 || ReqLineIdx !== '0 || ReqData !== '0
            || batch_written !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: Ready=%b ReqValid=%b ReqLineIdx=%0d bw=%b, want all 0",
                     Ready, ReqValid, ReqLineIdx, batch_written);
        end
        repeat (2) @(negedge clk);
        ReqAck = 1'b1; result_done = 1'b1;
        #1;
        n_cmp++;
        if (ReqValid !== 1'b0 || batch_written !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ignore: ReqValid=%b batch_written=%b, want 0 0", ReqValid, batch_written);
        end
        @(negedge clk);
        ReqAck = 1'b0; result_done = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (Ready !== 1'b1 || ReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_to_fill: Ready=%b ReqValid=%b, want 1 0", Ready, ReqValid);
        end
    endtask

    task automatic test_fill_drain();
        fill(32'h0, -1);
        drain(-1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_stall_and_drop();
        drain(3, -1, 1'b1, 1'b0);
        fill(32'h5A5A_0000, 8'h25);
        drain(-1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_write_with_done();
        drain(-1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        drain(-1, 7, 1'b0, 1'b0);
        drain(-1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill(32'hC3C3_0000, -1);
        drain(-1, -1, 1'b0, 1'b0);
        fill(32'h0F0F_F0F0, -1);
        drain(-1, -1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stall_and_drop();
        test_write_with_done();
        test_reset_mid_drain();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
